// File: rtl/xdma_narrow_arb_pkg.sv
// Shared types and constants for the XDMA narrow-channel packet arbiter.
package xdma_narrow_arb_pkg;

    // Arbiter FSM: IDLE arbitrates every cycle, LOCKED holds one requester
    // until its last beat is accepted.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Default number of narrow-message producers sharing the channel.
    localparam int unsigned DefaultNumInp = 3;

    // Requester index assignments; the highest index has top fixed priority.
    localparam int unsigned ReqFinish = 0;
    localparam int unsigned ReqGrant  = 1;
    localparam int unsigned ReqCfg    = 2;

endpackage

// File: rtl/xdma_narrow_arbiter_find_first_one_idx.sv
// Priority search returning the highest set bit index of a request vector
// plus a flag telling whether any bit was set at all.
module find_first_one_idx #(
    parameter int unsigned Width    = 3,
    parameter int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0]    in_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                valid_o
);

    // Upward scan so the last (highest) set bit overrides earlier ones.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < Width; i++) begin
            if (in_i[i]) begin
                idx_o   = IdxWidth'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xdma_narrow_arbiter.sv
// Packet-level arbiter sharing one XDMA narrow output channel among NumInp
// requesters. Forwarding is combinational; a grant is locked from the first
// presented beat until the beat carrying last is accepted, so a stalled beat
// never changes under the downstream AXI adapter.
// Optional: define XDMA_NARROW_ARB_RR_EN for round-robin arbitration instead
// of fixed highest-index-wins priority.
module xdma_narrow_arbiter
    import xdma_narrow_arb_pkg::*;
#(
    parameter int unsigned NumInp    = DefaultNumInp,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumInp-1:0]           req_valid_i,
    output logic [NumInp-1:0]           req_ready_o,
    input  logic [NumInp*DataWidth-1:0] req_data_i,
    input  logic [NumInp-1:0]           req_last_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DataWidth-1:0]        out_data_o,
    output logic                        out_last_o,
    output logic [IdxWidth-1:0]         out_src_o,
    output logic                        busy_o,
    output logic [CntWidth-1:0]         pkt_cnt_o
);

    arb_state_e          state_q, state_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [IdxWidth-1:0] win_idx;
    logic                win_vld;
    logic [IdxWidth-1:0] sel;
    logic                pkt_done;

`ifdef XDMA_NARROW_ARB_RR_EN
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [NumInp-1:0]   req_rot;
    logic [IdxWidth-1:0] rot_idx;

    // Rotate and mirror the requests so that rr_ptr lands on the MSB; the
    // highest-bit search then yields the first valid index at or above rr_ptr.
    always_comb begin
        req_rot = '0;
        for (int unsigned j = 0; j < NumInp; j++) begin
            for (int unsigned k = 0; k < NumInp; k++) begin
                if (k == (32'(rr_ptr_q) + NumInp - 1 - j) % NumInp) begin
                    req_rot[j] = req_valid_i[k];
                end
            end
        end
    end

    find_first_one_idx #(
        .Width    (NumInp),
        .IdxWidth (IdxWidth)
    ) u_find (
        .in_i    (req_rot),
        .idx_o   (rot_idx),
        .valid_o (win_vld)
    );

    // Undo the rotation to recover the real requester index.
    always_comb begin
        win_idx = IdxWidth'((32'(rr_ptr_q) + NumInp - 1 - 32'(rot_idx)) % NumInp);
    end

    // Pointer moves just past the requester whose packet completed.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pkt_done) begin
            rr_ptr_d = IdxWidth'((32'(sel) + 1) % NumInp);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    find_first_one_idx #(
        .Width    (NumInp),
        .IdxWidth (IdxWidth)
    ) u_find (
        .in_i    (req_valid_i),
        .idx_o   (win_idx),
        .valid_o (win_vld)
    );
`endif

    // Select the forwarded requester: locked owner, else the current winner.
    always_comb begin
        sel = '0;
        if (state_q == LOCKED) begin
            sel = lock_idx_q;
        end else if (win_vld) begin
            sel = win_idx;
        end
    end

    // Zero-latency forwarding of the selected requester and ready fan-back;
    // ready is held low during reset so no beat is consumed in that cycle.
    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        for (int unsigned i = 0; i < NumInp; i++) begin
            if (sel == IdxWidth'(i)) begin
                out_valid_o = req_valid_i[i];
                out_data_o  = req_data_i[i*DataWidth +: DataWidth];
                out_last_o  = req_last_i[i];
            end
        end
        req_ready_o = '0;
        for (int unsigned i = 0; i < NumInp; i++) begin
            req_ready_o[i] = out_ready_i && out_valid_o && !rst_i && (sel == IdxWidth'(i));
        end
        pkt_done = out_valid_o && out_ready_i && out_last_o && !rst_i;
    end

    // Next-state logic: lock on any presented beat that does not finish the packet.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (out_valid_o) begin
                    if (pkt_done) begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end else begin
                        lock_idx_d = sel;
                        state_d    = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (pkt_done) begin
                    cnt_d   = cnt_q + CntWidth'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, lock index and packet counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_src_o = sel;
    assign busy_o    = (state_q == LOCKED);
    assign pkt_cnt_o = cnt_q;

endmodule

// File: tb/tb_xdma_narrow_arbiter.sv
// Testbench for xdma_narrow_arbiter: directed reset/priority/stall cases, then
// randomized packet traffic checked by a scoreboard against a packet-level model.
module tb_xdma_narrow_arbiter;
    import xdma_narrow_arb_pkg::*;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int CW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i, req_ready_o, req_last_i;
    logic [N*DW-1:0] req_data_i;
    logic            out_valid_o, out_ready_i, out_last_o, busy_o;
    logic [DW-1:0]   out_data_o;
    logic [IW-1:0]   out_src_o;
    logic [CW-1:0]   pkt_cnt_o;

    always #5 clk = ~clk;

    xdma_narrow_arbiter #(
        .NumInp    (N),
        .DataWidth (DW),
        .CntWidth  (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_src_o   (out_src_o),
        .busy_o      (busy_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] src;
    } beat_t;

    beat_t         expq[$];
    int            checks = 0;
    int            failures = 0;
    int            m_owner = -1;
    int            m_ptr = 0;
    int            m_cnt = 0;
    bit            exp_valid = 0;
    bit            exp_busy = 0;
    bit            mon_en = 0;
    bit            active[N];
    int            len[N];
    int            pos[N];
    logic [DW-1:0] pdata[N][4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration rule: fixed highest index, or round-robin from ptr.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef XDMA_NARROW_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        req_valid_i = '0;
        req_last_i = '0;
        req_data_i = '0;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        m_owner = -1; m_ptr = 0; m_cnt = 0;
        exp_valid = 0; exp_busy = 0;
        expq.delete();
        for (int i = 0; i < N; i++) active[i] = 0;
    endtask

    // One randomized cycle: drive requesters, update the packet-level model.
    task automatic cycle(input int p_start, input int max_len, input int p_ready);
        logic [N-1:0] acc;
        int w;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!active[i] && $urandom_range(99) < p_start) begin
                active[i] = 1;
                len[i] = $urandom_range(1, max_len);
                pos[i] = 0;
                for (int b = 0; b < 4; b++) pdata[i][b] = {$urandom, $urandom};
            end
            req_valid_i[i] = active[i];
            req_last_i[i] = active[i] && (pos[i] == len[i] - 1);
            req_data_i[i*DW +: DW] = active[i] ? pdata[i][pos[i]] : {$urandom, $urandom};
        end
        out_ready_i = ($urandom_range(99) < p_ready);
        exp_busy = (m_owner >= 0);
        if (m_owner < 0) begin
            w = pick(req_valid_i, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                for (int b = pos[w]; b < len[w]; b++)
                    expq.push_back('{data: pdata[w][b], last: (b == len[w] - 1), src: IW'(w)});
            end
        end
        exp_valid = (m_owner >= 0);
        #1;
        acc = req_valid_i & req_ready_o;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (pos[i] == len[i] - 1) begin
                    active[i] = 0;
                    if (i == m_owner) begin
                        m_owner = -1;
                        m_cnt = (m_cnt + 1) % (1 << CW);
                        m_ptr = (i + 1) % N;
                    end
                end else begin
                    pos[i]++;
                end
            end
        end
    endtask

    // Scoreboard monitor: compares presented beats against the expected queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
                chk("busy", 64'(busy_o), 64'(exp_busy));
                if (out_valid_o) begin
                    if (expq.size() == 0) begin
                        chk("beat_expected", 64'(expq.size()), 64'd1);
                    end else begin
                        e = expq[0];
                        chk("src", 64'(out_src_o), 64'(e.src));
                        chk("data", out_data_o, e.data);
                        chk("last", 64'(out_last_o), 64'(e.last));
                        if (out_ready_i) begin
                            chk("req_ready", 64'(req_ready_o), 64'(1) << e.src);
                            void'(expq.pop_front());
                        end
                    end
                end
                if (!(out_valid_o && out_ready_i)) chk("req_ready_idle", 64'(req_ready_o), 64'd0);
                chk("pkt_cnt", 64'(pkt_cnt_o), 64'(m_cnt));
            end
        end
    end

    initial begin
        logic [N-1:0] v;
        int ptr, w;
        rst_i = 1'b1;
        req_valid_i = '0; req_last_i = '0; req_data_i = '0; out_ready_i = 1'b0;
        do_reset();

        // Reset then idle.
        #1;
        chk("idle_valid", 64'(out_valid_o), 64'd0);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_cnt", 64'(pkt_cnt_o), 64'd0);
        chk("idle_ready", 64'(req_ready_o), 64'd0);

        // All three valid, single-beat packets, ready always high.
        v = '1; ptr = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            req_valid_i = v; req_last_i = v; out_ready_i = 1'b1;
            for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = 64'h1000 + 64'(i);
            #1;
            w = pick(v, ptr);
            chk("prio_src", 64'(out_src_o), 64'(w));
            chk("prio_data", out_data_o, 64'h1000 + 64'(w));
            @(posedge clk);
            v[w] = 1'b0;
            ptr = (w + 1) % N;
        end
        @(negedge clk);
        req_valid_i = '0; req_last_i = '0;
        #1;
        chk("prio_cnt", 64'(pkt_cnt_o), 64'd3);

        // Reset asserted during beat 2 of a 3-beat packet from requester 1.
        @(negedge clk);
        req_valid_i = 3'b010; req_last_i = '0; out_ready_i = 1'b1;
        req_data_i[1*DW +: DW] = 64'hB1;
        @(posedge clk);
        @(negedge clk);
        req_data_i[1*DW +: DW] = 64'hB2;
        #1;
        chk("mid_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0; req_valid_i = '0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_cnt", 64'(pkt_cnt_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);

        // Lock on stall: requester 0 stalls, requester 2 arrives later.
        @(negedge clk);
        req_valid_i = 3'b001; req_last_i = 3'b101; out_ready_i = 1'b0;
        req_data_i[0 +: DW] = 64'h55; req_data_i[2*DW +: DW] = 64'h77;
        #1;
        chk("stall_src0", 64'(out_src_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 3'b101;
        #1;
        chk("stall_src1", 64'(out_src_o), 64'd0);
        chk("stall_data", out_data_o, 64'h55);
        chk("stall_busy", 64'(busy_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        out_ready_i = 1'b1;
        #1;
        chk("stall_accept", 64'(req_ready_o), 64'b001);
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 3'b100;
        #1;
        chk("stall_next_src", 64'(out_src_o), 64'd2);
        chk("stall_next_data", out_data_o, 64'h77);
        chk("stall_next_busy", 64'(busy_o), 64'd0);
        @(posedge clk);

        // Randomized traffic with scoreboard checking.
        do_reset();
        mon_en = 1;
        repeat (1500) cycle(30, 4, 70);
        repeat (300) cycle(100, 1, 100);
        repeat (600) cycle(60, 4, 50);
        repeat (60) cycle(0, 4, 100);
        mon_en = 0;
        chk("queue_drained", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xdma_narrow_arbiter.md
Name: xdma_narrow_arbiter

Overview:
Packet-level arbiter that shares one XDMA narrow output channel among NumInp requesters, e.g. cfg, grant and finish.
- Priority is fixed: the highest index wins, so cfg on the MSB has top priority.
- Once a packet is selected, the grant is locked until the beat with last set is accepted.
- Sits between the XDMA narrow-message producers and the AXI narrow-port adapter.

Parameters:
NumInp, 3, number of requesters; NumInp=1 must be legal.
DataWidth, 64, payload width per beat.
CntWidth, 16, width of the completed-packet counter.
IdxWidth, max(1,$clog2(NumInp)), derived; do not override.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NumInp  per-requester beat valid
req_ready_o  out  NumInp  per-requester beat ready
req_data_i  in  NumInp x DataWidth  per-requester payload
req_last_i  in  NumInp  per-requester last beat of packet
out_valid_o  out  1  granted beat valid
out_ready_i  in  1  downstream ready
out_data_o  out  DataWidth  granted payload
out_last_o  out  1  granted last flag
out_src_o  out  IdxWidth  index of the granted requester
busy_o  out  1  high while state is LOCKED
pkt_cnt_o  out  CntWidth  number of packets completed, wraps

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - state=IDLE, lock_idx=0, pkt_cnt_o=0, busy_o=0.
  - out_valid_o=0 and req_ready_o=0 unless some req_valid_i is high on the following cycle.
- Forwarding is zero-latency and combinational:
  - out_valid_o=req_valid_i[sel], out_data_o=req_data_i[sel], out_last_o=req_last_i[sel], out_src_o=sel.
  - req_ready_o[i]=out_ready_i && (i==sel) && out_valid_o; all other ready bits are 0.
- sel depends on state:
  - IDLE: the highest set index of req_valid_i. If none is set, out_valid_o=0 and out_src_o=0.
  - LOCKED: sel=lock_idx.
- FSM state IDLE:
  - No valid: stay in IDLE.
  - out_valid_o && out_ready_i && out_last_o: single-beat packet; stay in IDLE and increment pkt_cnt.
  - out_valid_o && !(out_ready_i && out_last_o): lock_idx<=sel and go to LOCKED. This covers a stalled beat and a non-last accepted beat.
- FSM state LOCKED:
  - Only lock_idx is forwarded; higher-priority arrivals are ignored.
  - out_valid_o && out_ready_i && out_last_o: go to IDLE and increment pkt_cnt.
  - Otherwise stay in LOCKED.
  - A valid drop by the locked requester mid-packet is a protocol violation. The arbiter stays LOCKED with out_valid_o=0 and waits.
- AXI rule: a presented beat never changes before it is accepted. This is guaranteed by locking on a stall.
- Simultaneous events:
  - Arbitration happens the cycle after a last beat is accepted.
  - In that cycle the FSM is in IDLE and forwards the new winner with no bubble.
- pkt_cnt wraps from 2^CntWidth-1 to 0.
- Reset asserted mid-packet: next cycle is IDLE, lock released, counter zeroed. No beat is accepted in the reset cycle (ready forced 0 while rst_i=1).
- NumInp=1: sel is always 0 and the FSM still tracks last for busy_o and the counter.

Optional Feature:
Macro XDMA_NARROW_ARB_RR_EN.
- Defined: round-robin among the requesters.
  - A rotating priority pointer rr_ptr (reset 0) is kept.
  - The IDLE winner is the first valid index at or above rr_ptr, searching upward with wrap-around.
  - On each completed packet, rr_ptr <= winner+1 mod NumInp.
- Undefined: fixed MSB-highest priority as described above; rr_ptr does not exist.

Decomposition:
- Package xdma_narrow_arb_pkg holds:
  - the state enum typedef (IDLE, LOCKED);
  - the constant for the default NumInp;
  - the requester index assignments: FINISH=0, GRANT=1, CFG=2.
- Sub-module: the codebase's existing find_first_one_idx performs the IDLE winner search, giving the highest set index plus a valid flag.
- Round-robin mode rotates the request vector by rr_ptr before find_first_one_idx and rotates the returned index back.

Test Plan:
- Reset then idle: req_valid_i=000 -> out_valid_o=0, busy_o=0, pkt_cnt_o=0.
- Priority: req_valid_i=111, all last=1, out_ready_i=1 -> out_src_o=2 in cycle 0, 1 in cycle 1, 0 in cycle 2; pkt_cnt_o=3.
- Lock on stall: req 0 valid with out_ready_i=0, then req 2 asserts -> out_src_o stays 0 and data is unchanged until ready; req 2 is served next.
- Multi-beat: req 1 sends 4 beats (last on beat 4) while req 2 asserts at beat 2 -> beats 1-4 all carry src=1, busy_o=1 during beats 2-4, then src=2 with no idle cycle.
- Reset mid-packet: rst_i=1 during beat 2 of 3 -> next cycle IDLE, pkt_cnt_o=0, req_ready_o=0 in the reset cycle.
- RR_EN defined: all three requesters continuously valid with single-beat packets -> grant order 0,1,2,0,1,2; counter wraps with CntWidth=2 after 4 packets to 0.
